// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, EX redirect flushes and data-memory wait stalls.
// Optional HAZARD_PERF_EN adds free-running bubble/flush/memory-wait performance counters.
module pipe_hazard_ctrl #(
  parameter int unsigned LOAD_USE_BUBBLES = 1,
  parameter int unsigned MEM_TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [6:0]  ex_opcode,
  input  logic [4:0]  ex_rd,
  input  logic        ex_rd_vld,
  input  logic        ex_redirect,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        ifid_flush,
  output logic        idreg_flush,
  output logic        ex_stall,
  output logic        mem_timeout,
`ifdef HAZARD_PERF_EN
  output logic [31:0] perf_bubble_cnt,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_memwait_cnt,
`endif
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    MEMW   = 2'd1,
    LDST   = 2'd2,
    UNUSED = 2'd3
  } state_t;

  localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 32'd1);
  localparam logic [2:0]  BUB_INIT  = 3'(LOAD_USE_BUBBLES - 32'd1);
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;

  state_t      state_r, state_nxt_s;
  logic [15:0] wait_cnt_r, wait_cnt_nxt_s;
  logic [2:0]  bub_cnt_r, bub_cnt_nxt_s;
  logic        timeout_r, timeout_nxt_s;
  logic        load_use_s, mem_wait_s;

  // Hazard detection against the load currently in EX
  always_comb begin
    load_use_s = (ex_opcode == OP_LOAD) && ex_rd_vld && (ex_rd != 5'd0) &&
                 ((id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd)));
    mem_wait_s = mem_req && !mem_ack;
  end

  // Next-state and stall/flush decode
  always_comb begin
    pc_stall       = 1'b0;
    ifid_stall     = 1'b0;
    ifid_flush     = 1'b0;
    idreg_flush    = 1'b0;
    ex_stall       = 1'b0;
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    bub_cnt_nxt_s  = bub_cnt_r;
    timeout_nxt_s  = 1'b0;
    if (rst) begin
      ifid_flush     = 1'b1;
      idreg_flush    = 1'b1;
      state_nxt_s    = RUN;
      wait_cnt_nxt_s = 16'd0;
      bub_cnt_nxt_s  = 3'd0;
    end else begin
      case (state_r)
        MEMW: begin
          if (mem_ack || !mem_req || (wait_cnt_r == WAIT_LAST)) begin
            // Release cycle: a redirect held in EX during the wait is applied now
            state_nxt_s    = RUN;
            wait_cnt_nxt_s = 16'd0;
            timeout_nxt_s  = mem_req && !mem_ack;
            if (ex_redirect) begin
              ifid_flush  = 1'b1;
              idreg_flush = 1'b1;
            end else begin
              ifid_flush  = 1'b0;
            end
          end else begin
            pc_stall       = 1'b1;
            ifid_stall     = 1'b1;
            ex_stall       = 1'b1;
            wait_cnt_nxt_s = wait_cnt_r + 16'd1;
          end
        end
        LDST: begin
          if (mem_wait_s) begin
            pc_stall       = 1'b1;
            ifid_stall     = 1'b1;
            ex_stall       = 1'b1;
            state_nxt_s    = MEMW;
            wait_cnt_nxt_s = 16'd1;
            bub_cnt_nxt_s  = 3'd0;
          end else if (ex_redirect) begin
            ifid_flush    = 1'b1;
            idreg_flush   = 1'b1;
            state_nxt_s   = RUN;
            bub_cnt_nxt_s = 3'd0;
          end else begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idreg_flush = 1'b1;
            if (bub_cnt_r <= 3'd1) begin
              state_nxt_s   = RUN;
              bub_cnt_nxt_s = 3'd0;
            end else begin
              bub_cnt_nxt_s = bub_cnt_r - 3'd1;
            end
          end
        end
        default: begin
          state_nxt_s = RUN;
          if (mem_wait_s) begin
            pc_stall       = 1'b1;
            ifid_stall     = 1'b1;
            ex_stall       = 1'b1;
            state_nxt_s    = MEMW;
            wait_cnt_nxt_s = 16'd1;
          end else if (ex_redirect) begin
            ifid_flush  = 1'b1;
            idreg_flush = 1'b1;
          end else if (load_use_s) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idreg_flush = 1'b1;
            if (LOAD_USE_BUBBLES > 32'd1) begin
              state_nxt_s   = LDST;
              bub_cnt_nxt_s = BUB_INIT;
            end else begin
              bub_cnt_nxt_s = 3'd0;
            end
          end else begin
            bub_cnt_nxt_s = 3'd0;
          end
        end
      endcase
    end
  end

  // State, counters and registered timeout pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= RUN;
      wait_cnt_r <= 16'd0;
      bub_cnt_r  <= 3'd0;
      timeout_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      bub_cnt_r  <= bub_cnt_nxt_s;
      timeout_r  <= timeout_nxt_s;
    end
  end

  assign mem_timeout = timeout_r && !rst;
  assign state       = state_r;

`ifdef HAZARD_PERF_EN
  // Bubble cycles are the only ones with idreg_flush but no ifid_flush
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_bubble_cnt  <= 32'd0;
      perf_flush_cnt   <= 32'd0;
      perf_memwait_cnt <= 32'd0;
    end else begin
      if (idreg_flush && !ifid_flush) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      else perf_bubble_cnt <= perf_bubble_cnt;
      if (ifid_flush) perf_flush_cnt <= perf_flush_cnt + 32'd1;
      else perf_flush_cnt <= perf_flush_cnt;
      if (ex_stall) perf_memwait_cnt <= perf_memwait_cnt + 32'd1;
      else perf_memwait_cnt <= perf_memwait_cnt;
    end
  end
`endif

endmodule
